idct2_control: RTL and testbench
================================

Name: idct2_control

Overview:
- Sequencing controller for the 2D inverse DCT-II datapath; mirror of the forward 2D DCT controller.
- Runs the vertical (column) inverse pass first. Each pass result goes into the shared intermediate/transpose buffer.
- Then runs the horizontal (row) inverse pass, streaming residual rows out under a valid/ready handshake.
- Drives the shared 1D transform core's direction select, input mux and buffer enables; input and output sides both support stalls.

Parameters:
- N, 8, transform points per pass (rows/columns per block); power of two, 4..32.
- CNT_W, $clog2(N), counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin a block; sampled only in IDLE.
- in_valid  input  1  coefficient column available at the core input during V pass.
- out_ready  input  1  downstream accepts the residual row during H pass.
- enable_write  output  1  intermediate buffer write enable.
- enable_read  output  1  intermediate buffer read enable.
- direction  output  1  0 = vertical pass, 1 = horizontal pass.
- mux  output  1  core input select: 0 = coefficient input, 1 = intermediate buffer.
- out_valid  output  1  residual row valid at core output.
- ready  output  1  controller idle, can accept start.
- done  output  1  one-cycle pulse after the last row handshake.
- counter  output  CNT_W  row/column index within the current pass.

Behaviour:
- Reset (reset==0 at a clk edge), also mid-operation: state=IDLE, counter=0, done=0.
  - Outputs immediately after reset: ready=1; enable_write, out_valid, direction, mux = 0; enable_read per Optional Feature.
  - Any partial block is discarded.
- States: IDLE, V, H, DONE (2-bit encoding from package).
- IDLE:
  - ready=1.
  - start=1 -> V with counter=0 next cycle.
  - start in any other state is ignored (not queued).
- V:
  - direction=0, mux=0.
  - enable_write = in_valid (combinational).
  - Counter increments only when in_valid=1.
  - in_valid=1 with counter==N-1 -> H, counter wraps to 0.
  - in_valid=0 holds state and counter (stall).
- H:
  - direction=1, mux=1, enable_write=0, out_valid=1.
  - Counter increments only on handshake (out_valid & out_ready).
  - Handshake at counter==N-1 -> DONE, counter=0.
  - out_ready=0 holds counter; buffer read address stays stable.
- DONE:
  - done=1 for exactly one cycle, ready=0.
  - Unconditionally -> IDLE; start during DONE is ignored.
- Latency:
  - Minimum start-to-done is 2N+2 cycles (1 cycle to enter V, N cycles of V, N cycles of H, 1 cycle DONE), with no stalls.
  - Each stall cycle adds exactly one cycle.
- counter is registered; wraps modulo N only at pass boundaries. The unreachable state encoding recovers to IDLE next cycle.
- All outputs except counter and done decode combinationally from state, with in_valid gating for enable_write. No glitch-sensitive consumers.

Optional Feature:
- Macro IDCT2_READ_GATE_EN.
- Defined: enable_read=1 only in H (buffer read for the row pass), 0 in IDLE/V/DONE, including after reset.
- Undefined: enable_read tied to 1 in all states, matching the forward controller.

Decomposition:
- Package idct2_pkg holds:
  - the state typedef/localparams (IDLE=2'b00, V=2'b01, H=2'b10, DONE=2'b11);
  - default N;
  - direction/mux encoding constants (DIR_VERT=0, DIR_HORZ=1, MUX_IN=0, MUX_BUF=1).
- No sub-module: counter and FSM stay inline, in a single always block plus output decode.

Test Plan:
- reset=0 for 2 cycles, then 1 -> ready=1, done=0, counter=0, out_valid=0, enable_write=0; enable_read=1 (0 with IDCT2_READ_GATE_EN).
- start=1 pulse, in_valid=1, out_ready=1 throughout, N=8:
  - enable_write high for 8 cycles with counter 0..7, direction=0;
  - then out_valid high for 8 cycles, direction=1, mux=1;
  - done pulses on cycle 18 after start; ready=1 on cycle 19.
- in_valid deasserted at counter=3 for 2 cycles in V -> counter holds at 3, enable_write=0 during stall, done delayed by exactly 2 cycles.
- out_ready=0 at counter=5 in H for 3 cycles -> out_valid stays 1, counter holds at 5, done delayed by 3 cycles.
- start held high through a whole block -> exactly one block runs; a second block starts only from IDLE after done.
- reset=0 asserted in H at counter=4 -> next cycle state IDLE, counter=0, ready=1, out_valid=0, no done pulse.

Source files
------------

// File: rtl/idct2_pkg.sv
// idct2_pkg: shared state encoding, default size and core select constants for the 2D IDCT controller
package idct2_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    V    = 2'b01,
    H    = 2'b10,
    DONE = 2'b11
  } state_t;
  localparam int N_DEFAULT = 8;
  localparam logic DIR_VERT = 1'b0;
  localparam logic DIR_HORZ = 1'b1;
  localparam logic MUX_IN   = 1'b0;
  localparam logic MUX_BUF  = 1'b1;
endpackage

// File: rtl/idct2_control_if.sv
// idct2_control_if: handshake and datapath-control bundle between the IDCT controller (master) and its datapath/environment (slave)
interface idct2_control_if import idct2_pkg::*; #(
  parameter int N = N_DEFAULT,
  parameter int CNT_W = $clog2(N)
);
  logic start;
  logic in_valid;
  logic out_ready;
  logic enable_write;
  logic enable_read;
  logic direction;
  logic mux;
  logic out_valid;
  logic ready;
  logic done;
  logic [CNT_W-1:0] counter;
  modport master (
    input  start, in_valid, out_ready,
    output enable_write, enable_read, direction, mux, out_valid, ready, done, counter
  );
  modport slave (
    output start, in_valid, out_ready,
    input  enable_write, enable_read, direction, mux, out_valid, ready, done, counter
  );
endinterface

// File: rtl/idct2_control.sv
// idct2_control: sequences V (column) then H (row) inverse passes over an N-point core; ports clk, reset (sync active-low), bus (master: start/in_valid/out_ready in; enable_write/enable_read/direction/mux/out_valid/ready/done/counter out); IDCT2_READ_GATE_EN gates enable_read to the H pass
module idct2_control import idct2_pkg::*; #(
  parameter int N = N_DEFAULT,
  parameter int CNT_W = $clog2(N)
) (
  input logic clk,
  input logic reset,
  idct2_control_if.master bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic done_q, done_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done_n = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_n = V;
        cnt_n = '0;
      end
      V: if (bus.in_valid) begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        state_n = (cnt == LAST) ? H : V;
      end
      H: if (bus.out_ready) begin
        cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
        state_n = (cnt == LAST) ? DONE : H;
        done_n = (cnt == LAST);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done_q <= done_n;
    end
  end
  assign bus.ready = (state == IDLE);
  assign bus.enable_write = (state == V) && bus.in_valid;
  assign bus.direction = (state == H) ? DIR_HORZ : DIR_VERT;
  assign bus.mux = (state == H) ? MUX_BUF : MUX_IN;
  assign bus.out_valid = (state == H);
  assign bus.done = done_q;
  assign bus.counter = cnt;
`ifdef IDCT2_READ_GATE_EN
  assign bus.enable_read = (state == H);
`else
  assign bus.enable_read = 1'b1;
`endif
endmodule

// File: tb/tb_idct2_control.sv
// tb_idct2_control: directed scenario checks of idct2_control with N=8
module tb_idct2_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  idct2_control_if #(.N(8)) b();
  idct2_control #(.N(8)) dut (.clk(clk), .reset(reset), .bus(b.master));
  always #5 clk = ~clk;
`ifdef IDCT2_READ_GATE_EN
  localparam logic ER_IDLE = 1'b0;
`else
  localparam logic ER_IDLE = 1'b1;
`endif
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    b.start = 1'b0;
    b.in_valid = 1'b0;
    b.out_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    total++;
    if ({b.ready, b.done, b.counter, b.out_valid, b.enable_write, b.direction, b.mux} !== {1'b1, 1'b0, 3'd0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outs: got rdy=%b done=%b cnt=%0d ov=%b ew=%b dir=%b mux=%b", b.ready, b.done, b.counter, b.out_valid, b.enable_write, b.direction, b.mux);
    end
    total++;
    if (b.enable_read !== ER_IDLE) begin
      bad++;
      $display("FAIL reset_enable_read: got %b want %b", b.enable_read, ER_IDLE);
    end
  endtask
  task automatic test_nominal();
    int cyc;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    for (cyc = 1; cyc <= 18; cyc++) begin
      if (cyc <= 8) begin
        total++;
        if ({b.enable_write, b.direction, b.mux, b.out_valid, b.counter} !== {4'b1000, 3'(cyc - 1)}) begin
          bad++;
          $display("FAIL nominal_v cyc%0d: ew=%b dir=%b mux=%b ov=%b cnt=%0d want cnt=%0d", cyc, b.enable_write, b.direction, b.mux, b.out_valid, b.counter, cyc - 1);
        end
      end else if (cyc <= 16) begin
        total++;
        if ({b.enable_write, b.direction, b.mux, b.out_valid, b.enable_read, b.counter} !== {5'b01111, 3'(cyc - 9)}) begin
          bad++;
          $display("FAIL nominal_h cyc%0d: ew=%b dir=%b mux=%b ov=%b er=%b cnt=%0d want cnt=%0d", cyc, b.enable_write, b.direction, b.mux, b.out_valid, b.enable_read, b.counter, cyc - 9);
        end
      end else if (cyc == 17) begin
        total++;
        if ({b.done, b.ready, b.out_valid, b.counter} !== {3'b100, 3'd0}) begin
          bad++;
          $display("FAIL nominal_done: done=%b rdy=%b ov=%b cnt=%0d want done=1 rdy=0 ov=0 cnt=0", b.done, b.ready, b.out_valid, b.counter);
        end
      end else begin
        total++;
        if ({b.done, b.ready, b.enable_read} !== {1'b0, 1'b1, ER_IDLE}) begin
          bad++;
          $display("FAIL nominal_idle: done=%b rdy=%b er=%b", b.done, b.ready, b.enable_read);
        end
      end
      if (cyc < 18) step();
    end
  endtask
  task automatic test_v_stall();
    int cyc;
    int stalled;
    stalled = 0;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    cyc = 1;
    while (!b.done && cyc < 100) begin
      if (!b.direction && !b.ready && b.counter == 3'd3 && stalled < 2) begin
        b.in_valid = 1'b0;
        stalled++;
        #1;
        total++;
        if (b.enable_write !== 1'b0 || b.counter !== 3'd3) begin
          bad++;
          $display("FAIL v_stall_hold: ew=%b cnt=%0d want ew=0 cnt=3", b.enable_write, b.counter);
        end
      end else b.in_valid = 1'b1;
      step();
      cyc++;
    end
    b.in_valid = 1'b1;
    total++;
    if (cyc !== 19) begin
      bad++;
      $display("FAIL v_stall_latency: done at cycle %0d want 19", cyc);
    end
    total++;
    if (stalled !== 2) begin
      bad++;
      $display("FAIL v_stall_seen: stall cycles %0d want 2", stalled);
    end
    step();
  endtask
  task automatic test_h_stall();
    int cyc;
    int stalled;
    stalled = 0;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    cyc = 1;
    while (!b.done && cyc < 100) begin
      if (b.direction && b.counter == 3'd5 && stalled < 3) begin
        b.out_ready = 1'b0;
        stalled++;
        total++;
        if (b.out_valid !== 1'b1 || b.counter !== 3'd5) begin
          bad++;
          $display("FAIL h_stall_hold: ov=%b cnt=%0d want ov=1 cnt=5", b.out_valid, b.counter);
        end
      end else b.out_ready = 1'b1;
      step();
      cyc++;
    end
    b.out_ready = 1'b1;
    total++;
    if (cyc !== 20) begin
      bad++;
      $display("FAIL h_stall_latency: done at cycle %0d want 20", cyc);
    end
    total++;
    if (stalled !== 3) begin
      bad++;
      $display("FAIL h_stall_seen: stall cycles %0d want 3", stalled);
    end
    step();
  endtask
  task automatic test_start_held();
    int cyc;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    b.start = 1'b1;
    step();
    cyc = 1;
    while (!b.done && cyc < 100) begin
      step();
      cyc++;
    end
    total++;
    if (cyc !== 17) begin
      bad++;
      $display("FAIL held_latency: done at cycle %0d want 17", cyc);
    end
    step();
    total++;
    if (b.ready !== 1'b1 || b.done !== 1'b0) begin
      bad++;
      $display("FAIL held_idle: rdy=%b done=%b want rdy=1 done=0", b.ready, b.done);
    end
    step();
    b.start = 1'b0;
    total++;
    if ({b.ready, b.direction, b.enable_write, b.counter} !== {3'b001, 3'd0}) begin
      bad++;
      $display("FAIL held_restart: rdy=%b dir=%b ew=%b cnt=%0d want rdy=0 dir=0 ew=1 cnt=0", b.ready, b.direction, b.enable_write, b.counter);
    end
    cyc = 0;
    while (!b.done && cyc < 100) begin
      step();
      cyc++;
    end
    total++;
    if (cyc !== 16) begin
      bad++;
      $display("FAIL held_second_block: done after %0d more cycles want 16", cyc);
    end
    step();
  endtask
  task automatic test_reset_mid();
    int cyc;
    int dones;
    dones = 0;
    b.in_valid = 1'b1;
    b.out_ready = 1'b1;
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    cyc = 1;
    while (!(b.direction && b.counter == 3'd4) && cyc < 100) begin
      step();
      cyc++;
    end
    total++;
    if (cyc !== 13) begin
      bad++;
      $display("FAIL mid_reach_h4: reached at cycle %0d want 13", cyc);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if ({b.ready, b.counter, b.out_valid, b.done, b.direction, b.enable_read} !== {1'b1, 3'd0, 3'b000, ER_IDLE}) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b cnt=%0d ov=%b done=%b dir=%b er=%b", b.ready, b.counter, b.out_valid, b.done, b.direction, b.enable_read);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (b.done) dones++;
    end
    total++;
    if (dones !== 0 || b.ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_no_done: done pulses %0d rdy=%b want 0 and 1", dones, b.ready);
    end
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_v_stall();
    test_h_stall();
    test_start_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
